// File: rtl/para_load_sched.sv
// Parameter-block load scheduler: arbitrates boot/MCU load requests, commands the
// flash read engine, frames and checksums the load, then paces the drain to the consumer.
module para_load_sched #(
  parameter int unsigned WORD_NUM  = 256,
  parameter logic [23:0] BOOT_ADDR = 24'h100000,
  parameter logic [19:0] TIMEOUT   = 20'hFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_boot_start,
  input  logic        i_mcu_req,
  input  logic [23:0] i_mcu_addr,
  output logic        o_flash_rd_req,
  output logic [23:0] o_flash_addr,
  output logic [15:0] o_flash_len,
  input  logic        i_flash_ack,
  input  logic [15:0] i_flash_data,
  input  logic        i_flash_data_vld,
  output logic        o_param_load,
  output logic        o_option,
  input  logic        i_fifo_empty,
  input  logic        i_cons_rdy,
  output logic        o_data_req,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_req_drop
);

  localparam logic [15:0] WN    = 16'(WORD_NUM);
  localparam logic [15:0] WN_M1 = 16'(WORD_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_CHECK, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        boot_pend_q, boot_pend_d;
  logic        mcu_pend_q, mcu_pend_d;
  logic [23:0] mcu_addr_q, mcu_addr_d;
  logic [23:0] flash_addr_q, flash_addr_d;
  logic [15:0] flash_len_q, flash_len_d;
  logic        option_q, option_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] drain_cnt_q, drain_cnt_d;
  logic [19:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        drop_q, drop_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      boot_pend_q  <= 1'b0;
      mcu_pend_q   <= 1'b0;
      mcu_addr_q   <= '0;
      flash_addr_q <= '0;
      flash_len_q  <= '0;
      option_q     <= 1'b0;
      word_cnt_q   <= '0;
      sum_q        <= '0;
      exp_q        <= '0;
      drain_cnt_q  <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_pend_q  <= boot_pend_d;
      mcu_pend_q   <= mcu_pend_d;
      mcu_addr_q   <= mcu_addr_d;
      flash_addr_q <= flash_addr_d;
      flash_len_q  <= flash_len_d;
      option_q     <= option_d;
      word_cnt_q   <= word_cnt_d;
      sum_q        <= sum_d;
      exp_q        <= exp_d;
      drain_cnt_q  <= drain_cnt_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    boot_pend_d  = boot_pend_q;
    mcu_pend_d   = mcu_pend_q;
    mcu_addr_d   = mcu_addr_q;
    flash_addr_d = flash_addr_q;
    flash_len_d  = flash_len_q;
    option_d     = option_q;
    word_cnt_d   = word_cnt_q;
    sum_d        = sum_q;
    exp_d        = exp_q;
    drain_cnt_d  = drain_cnt_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    drop_d       = i_mcu_req & mcu_pend_q;
    o_data_req   = 1'b0;

    // A word from the engine outside the load window is an overrun; it is dropped.
    if (i_flash_data_vld && state_q != S_IDLE && state_q != S_LOAD) begin
      err_d      = 1'b1;
      err_code_d = 2'd3;
    end

    unique case (state_q)
      S_IDLE: begin
        if (boot_pend_q || mcu_pend_q) begin
          state_d      = S_REQ;
          option_d     = ~boot_pend_q;
          flash_addr_d = boot_pend_q ? BOOT_ADDR : mcu_addr_q;
          flash_len_d  = WN;
          word_cnt_d   = '0;
          sum_d        = '0;
          exp_d        = '0;
          drain_cnt_d  = '0;
          tmo_d        = '0;
          err_d        = 1'b0;
          err_code_d   = 2'd0;
          if (boot_pend_q) boot_pend_d = 1'b0;
          else             mcu_pend_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (i_flash_ack) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Error is flagged as the idle count reaches TIMEOUT; the abort follows a cycle later.
        if (tmo_q == TIMEOUT) begin
          state_d = S_ERR;
        end else if (i_flash_data_vld) begin
          tmo_d      = '0;
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == WN_M1) begin
            exp_d   = i_flash_data;
            state_d = S_CHECK;
          end else begin
            sum_d = sum_q + i_flash_data;
          end
        end else begin
          tmo_d = tmo_q + 20'd1;
          if (tmo_q + 20'd1 == TIMEOUT) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
        end
      end
      S_CHECK: begin
        if (sum_q == exp_q) begin
          state_d = S_DRAIN;
        end else begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = S_ERR;
        end
      end
      S_DRAIN: begin
        // The final strobe discards the checksum word without waiting for the consumer.
        if (drain_cnt_q == WN_M1) begin
          o_data_req = 1'b1;
          state_d    = S_DONE;
        end else if (i_cons_rdy && !i_fifo_empty) begin
          o_data_req  = 1'b1;
          drain_cnt_d = drain_cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // New requests win over a same-cycle grant; a second MCU request is dropped.
    if (i_boot_start) boot_pend_d = 1'b1;
    if (i_mcu_req && !mcu_pend_q) begin
      mcu_pend_d = 1'b1;
      mcu_addr_d = i_mcu_addr;
    end
  end

  assign o_flash_rd_req = (state_q == S_REQ);
  assign o_flash_addr   = flash_addr_q;
  assign o_flash_len    = flash_len_q;
  assign o_param_load   = (state_q == S_LOAD);
  assign o_option       = option_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_err          = err_q;
  assign o_err_code     = err_code_q;
  assign o_req_drop     = drop_q;

endmodule

// File: tb/tb_para_load_sched.sv
// Self-checking bench for para_load_sched: table-driven jobs, hand-written corner
// sequences (priority, drop, timeout, overrun, reset in drain) and randomized jobs.
module tb_para_load_sched;
  localparam int          N    = 4;
  localparam logic [19:0] TMO  = 20'd16;
  localparam logic [23:0] BOOT = 24'h100000;

  typedef logic [N-1:0][15:0] blk_t;
  typedef struct packed {
    blk_t       w;
    logic       exp_ok;
    logic [1:0] exp_code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_boot_start = 1'b0, i_mcu_req = 1'b0;
  logic [23:0] i_mcu_addr = '0;
  logic        i_flash_ack = 1'b0, i_flash_data_vld = 1'b0;
  logic [15:0] i_flash_data = '0;
  logic        i_fifo_empty = 1'b0, i_cons_rdy = 1'b0;
  logic        o_flash_rd_req, o_param_load, o_option, o_data_req, o_busy, o_done, o_err, o_req_drop;
  logic [23:0] o_flash_addr;
  logic [15:0] o_flash_len;
  logic [1:0]  o_err_code;

  para_load_sched #(.WORD_NUM(N), .BOOT_ADDR(BOOT), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_boot_start(i_boot_start), .i_mcu_req(i_mcu_req), .i_mcu_addr(i_mcu_addr),
    .o_flash_rd_req(o_flash_rd_req), .o_flash_addr(o_flash_addr), .o_flash_len(o_flash_len),
    .i_flash_ack(i_flash_ack), .i_flash_data(i_flash_data), .i_flash_data_vld(i_flash_data_vld),
    .o_param_load(o_param_load), .o_option(o_option),
    .i_fifo_empty(i_fifo_empty), .i_cons_rdy(i_cons_rdy), .o_data_req(o_data_req),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
    .o_req_drop(o_req_drop)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt = 0;
  logic cur_opt = 1'b0;
  logic [24:0] exp_q[$];   // expected commands in service order: {option, addr}

  always @(negedge clk) if (o_req_drop) drop_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // reference model: checksum rule applied to a whole block
  function automatic logic cks_ok(input blk_t w);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < N - 1; i++) s = s + w[i];
    return s == w[N-1];
  endfunction

  task automatic pulse(input logic b, input logic m, input logic [23:0] a);
    i_boot_start = b; i_mcu_req = m; i_mcu_addr = a;
    step();
    i_boot_start = 1'b0; i_mcu_req = 1'b0;
  endtask

  task automatic serve_req(input logic overrun);
    logic [24:0] e;
    e = '0;
    if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
    else e = exp_q.pop_front();
    for (int k = 0; k < 20; k++) begin
      #1;
      if (o_flash_rd_req) break;
      step();
    end
    chk("rd_req_seen", o_flash_rd_req, 1);
    chk("flash_addr", o_flash_addr, e[23:0]);
    chk("flash_len", o_flash_len, N);
    chk("option", o_option, e[24]);
    chk("err_clr_on_start", {o_err, o_err_code}, 0);
    cur_opt = e[24];
    if (overrun) begin
      i_flash_data_vld = 1'b1;
      step();
      i_flash_data_vld = 1'b0;
      #1;
      chk("overrun_err", {o_err, o_err_code, o_flash_rd_req}, {1'b1, 2'd3, 1'b1});
    end
    i_flash_ack = 1'b1;
    step();
    i_flash_ack = 1'b0;
    #1;
    chk("ack_to_load", {o_flash_rd_req, o_param_load}, 2'b01);
  endtask

  task automatic feed(input blk_t w, input int gap_max, input logic inj);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) step();
      i_flash_data = w[i];
      i_flash_data_vld = 1'b1;
      if (inj && i == 0) begin i_mcu_req = 1'b1; i_mcu_addr = 24'h300000; end
      if (inj && i == 2) begin i_mcu_req = 1'b1; i_mcu_addr = 24'h400000; end
      #1;
      chk("param_load", o_param_load, 1);
      step();
      i_flash_data_vld = 1'b0;
      i_mcu_req = 1'b0;
    end
  endtask

  task automatic finish_job(input logic exp_ok, input logic [1:0] exp_code, input logic rnd);
    int strobes, dones, illegal, cyc;
    logic rdy, emp;
    strobes = 0; dones = 0; illegal = 0; cyc = 0;
    #1;
    chk("check_cycle", {o_busy, o_param_load, o_data_req, o_done}, 4'b1000);
    step();
    for (cyc = 0; cyc < 200; cyc++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      emp = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_cons_rdy = rdy; i_fifo_empty = emp;
      #1;
      if (!o_busy) break;
      if (o_done) dones++;
      if (o_data_req) begin
        if (strobes < N - 1 && !(rdy && !emp)) illegal++;
        strobes++;
      end
      step();
    end
    i_cons_rdy = 1'b0;
    chk("job_ends", o_busy, 0);
    chk("strobes", strobes, exp_ok ? N : 0);
    chk("done_pulses", dones, exp_ok ? 1 : 0);
    chk("illegal_strobes", illegal, 0);
    chk("err_flags", {o_err, o_err_code}, {exp_code != 2'd0, exp_code});
    chk("option_hold", o_option, cur_opt);
    if (!exp_ok) chk("err_cycles", cyc, 1);
  endtask

  vec_t tbl[5];

  initial begin
    int d0;
    blk_t w;
    logic ok;
    logic [23:0] a;
    logic src;

    tbl[0] = '{w: {16'd6, 16'd3, 16'd2, 16'd1}, exp_ok: 1'b1, exp_code: 2'd0};
    tbl[1] = '{w: {16'd7, 16'd3, 16'd2, 16'd1}, exp_ok: 1'b0, exp_code: 2'd1};
    tbl[2] = '{w: {16'h0000, 16'h0000, 16'h0001, 16'hFFFF}, exp_ok: 1'b1, exp_code: 2'd0};
    tbl[3] = '{w: {16'h0005, 16'h0005, 16'h8000, 16'h8000}, exp_ok: 1'b1, exp_code: 2'd0};
    tbl[4] = '{w: {16'h0001, 16'h0000, 16'h0000, 16'h0000}, exp_ok: 1'b0, exp_code: 2'd1};

    repeat (3) step();
    #1;
    chk("reset_outputs", {o_flash_rd_req, o_flash_addr, o_flash_len, o_param_load, o_option,
                          o_data_req, o_busy, o_done, o_err, o_err_code, o_req_drop}, 0);
    rst = 1'b0;
    step();

    // table-driven boot jobs
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back({1'b0, BOOT});
      pulse(1'b1, 1'b0, '0);
      serve_req(1'b0);
      feed(tbl[t].w, 0, 1'b0);
      finish_job(tbl[t].exp_ok, tbl[t].exp_code, 1'b0);
    end

    // boot and MCU in the same cycle: boot first, then MCU
    exp_q.push_back({1'b0, BOOT});
    exp_q.push_back({1'b1, 24'h200000});
    pulse(1'b1, 1'b1, 24'h200000);
    serve_req(1'b0); feed(tbl[0].w, 2, 1'b0); finish_job(1'b1, 2'd0, 1'b0);
    serve_req(1'b0); feed(tbl[3].w, 2, 1'b0); finish_job(1'b1, 2'd0, 1'b0);

    // two MCU requests during a boot job: second dropped, first address kept
    exp_q.push_back({1'b0, BOOT});
    exp_q.push_back({1'b1, 24'h300000});
    d0 = drop_cnt;
    pulse(1'b1, 1'b0, '0);
    serve_req(1'b0); feed(tbl[0].w, 0, 1'b1); finish_job(1'b1, 2'd0, 1'b0);
    chk("drop_count", drop_cnt - d0, 1);
    serve_req(1'b0); feed(tbl[0].w, 0, 1'b0); finish_job(1'b1, 2'd0, 1'b0);

    // word overrun during REQ: sticky code 3, job still completes
    exp_q.push_back({1'b0, BOOT});
    pulse(1'b1, 1'b0, '0);
    serve_req(1'b1); feed(tbl[0].w, 0, 1'b0); finish_job(1'b1, 2'd3, 1'b0);

    // timeout after 2 words: error after 16 idle cycles, busy drops 2 cycles later
    exp_q.push_back({1'b0, BOOT});
    pulse(1'b1, 1'b0, '0);
    serve_req(1'b0);
    for (int i = 0; i < 2; i++) begin
      i_flash_data = 16'(i + 1); i_flash_data_vld = 1'b1;
      step();
    end
    i_flash_data_vld = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (o_err || !o_param_load) ok = 1'b1;
      step();
    end
    chk("tmo_early_err", ok, 0);
    #1;
    chk("tmo_err", {o_err, o_err_code, o_busy}, {1'b1, 2'd2, 1'b1});
    step(); #1;
    chk("tmo_err_state", {o_busy, o_param_load, o_flash_rd_req}, 3'b100);
    step(); #1;
    chk("tmo_idle", {o_busy, o_done, o_err, o_err_code}, {1'b0, 1'b0, 1'b1, 2'd2});

    // reset asserted in DRAIN
    exp_q.push_back({1'b0, BOOT});
    pulse(1'b1, 1'b0, '0);
    serve_req(1'b0); feed(tbl[0].w, 0, 1'b0);
    i_cons_rdy = 1'b0;
    step(); step();
    i_cons_rdy = 1'b1; i_fifo_empty = 1'b0;
    #1;
    chk("drain_strobe", {o_busy, o_data_req}, 2'b11);
    rst = 1'b1;
    step(); #1;
    chk("rst_in_drain", {o_flash_rd_req, o_flash_addr, o_flash_len, o_param_load, o_option,
                         o_data_req, o_busy, o_done, o_err, o_err_code, o_req_drop}, 0);
    rst = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      if (o_done || o_busy || o_err) ok = 1'b1;
    end
    chk("quiet_after_rst", ok, 0);
    i_cons_rdy = 1'b0;
    exp_q.push_back({1'b0, BOOT});
    pulse(1'b1, 1'b0, '0);
    serve_req(1'b0); feed(tbl[2].w, 1, 1'b0); finish_job(1'b1, 2'd0, 1'b0);

    // randomized jobs against the checksum model
    for (int r = 0; r < 20; r++) begin
      src = 1'($urandom_range(0, 1));
      a = 24'($urandom());
      for (int i = 0; i < N; i++) w[i] = 16'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        w[N-1] = '0;
        for (int i = 0; i < N - 1; i++) w[N-1] = w[N-1] + w[i];
      end
      ok = cks_ok(w);
      exp_q.push_back({src, src ? a : BOOT});
      pulse(!src, src, a);
      serve_req(1'b0);
      feed(w, 4, 1'b0);
      finish_job(ok, ok ? 2'd0 : 2'd1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/para_load_sched.md
Name: para_load_sched

Overview:
- Schedules parameter-block loads from SPI flash into the parameter FIFO path.
- Arbitrates between two requesters: the boot-time auto load and MCU-initiated reloads.
- Issues read commands to the flash read engine, frames the load window, counts and checksums the words, then paces the drain toward the downstream consumer.
- Sits between the APB/MCU register bank, the flash read engine, and the parameter FIFO/loader.

Parameters:
- WORD_NUM, 256: words per parameter block, checksum word included; legal range 2..65535.
- BOOT_ADDR, 24'h100000: flash byte address used for boot loads.
- TIMEOUT, 20'hFFFFF: maximum idle cycles between words in LOAD before the load aborts.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_boot_start  in  1  pulse: request a boot load from BOOT_ADDR
- i_mcu_req  in  1  pulse: request an MCU reload
- i_mcu_addr  in  24  flash address for MCU reload; sampled when i_mcu_req=1
- o_flash_rd_req  out  1  read command valid; held until i_flash_ack
- o_flash_addr  out  24  command address
- o_flash_len  out  16  command length in words (= WORD_NUM)
- i_flash_ack  in  1  engine accepts the command
- i_flash_data  in  16  read word
- i_flash_data_vld  in  1  read word valid
- o_param_load  out  1  load window; high in LOAD
- o_option  out  1  source of the active job: 0 = boot, 1 = MCU
- i_fifo_empty  in  1  parameter FIFO empty
- i_cons_rdy  in  1  consumer can accept a word this cycle
- o_data_req  out  1  FIFO read strobe toward the consumer
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  1-cycle pulse when a job completes successfully
- o_err  out  1  sticky error flag; cleared on the next job start
- o_err_code  out  2  0 none, 1 checksum mismatch, 2 timeout, 3 word overrun
- o_req_drop  out  1  1-cycle pulse when an MCU request is discarded

Behaviour:
- Reset: state IDLE, all pending flags cleared.
- Reset: every output is 0 (o_flash_addr=0, o_flash_len=0, o_err_code=0).
- A reset asserted mid-job aborts the job immediately; no o_done and no o_err follow.
- Pending flags: i_boot_start sets boot_pend. i_mcu_req sets mcu_pend and latches i_mcu_addr.
- If mcu_pend is already 1 when i_mcu_req arrives, the request is discarded: the first stored address is kept and o_req_drop pulses.
- IDLE: boot_pend has priority over mcu_pend. The granted pend flag clears and the next state is REQ.
- IDLE: on entry to REQ, o_option is set to the source, the word counter and checksum clear, o_err and o_err_code clear, o_flash_addr loads, and o_flash_len = WORD_NUM.
- REQ: o_flash_rd_req=1 until the cycle with i_flash_ack=1. The cycle after the ack: o_flash_rd_req=0, state LOAD.
- LOAD: o_param_load=1. Each i_flash_data_vld increments the word counter.
  - Words 0..WORD_NUM-2 are added to a 16-bit running sum, mod 2^16.
  - Word WORD_NUM-1 is latched as the expected checksum.
  - When the counter reaches WORD_NUM, the next state is CHECK.
- LOAD timeout: the timeout counter resets on each valid word. When it reaches TIMEOUT: o_err=1, code 2, state ERR.
- CHECK: takes 1 cycle. sum == expected -> DRAIN; otherwise o_err=1, code 1, state ERR.
- DRAIN: o_data_req = i_cons_rdy & ~i_fifo_empty, combinational within the state, counted by a drain counter.
  - After WORD_NUM-1 strobes, the checksum word is discarded with one extra strobe regardless of i_cons_rdy.
  - Then state DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_option holds its value until the next job.
- ERR: takes 1 cycle.
  - If entered with 1 <= counter < WORD_NUM, issue no further flash commands; the next state is IDLE.
  - A job entering ERR leaves its pend flag cleared; it is not retried automatically.
- Word overrun: i_flash_data_vld outside LOAD while o_busy=1 sets o_err=1, code 3. The state is unchanged and the word is ignored.
- Requests that arrive while busy are served after return to IDLE, in priority order.
- i_boot_start arriving while boot_pend=1 is merged silently.

Test Plan:
- Boot load, WORD_NUM=4, words 1,2,3,6 -> o_flash_addr=0x100000, o_flash_len=4, o_param_load high for 4 words. CHECK passes. With i_cons_rdy=1 and FIFO not empty, exactly 4 o_data_req strobes, then o_done pulse and o_option=0.
- Same job with last word 7 -> o_err=1, o_err_code=1, no o_data_req strobes, back to IDLE. The next job clears o_err.
- i_boot_start and i_mcu_req (addr 0x200000) in the same cycle -> boot served first, o_option=0. Then the MCU job with o_flash_addr=0x200000 and o_option=1.
- Two i_mcu_req during a boot job (addr 0x300000, then 0x400000) -> one o_req_drop. The MCU job uses 0x300000.
- TIMEOUT=16, engine stops after 2 words -> o_err_code=2 at the 16th idle cycle, o_busy drops 2 cycles later.
- i_rst asserted in DRAIN -> all outputs 0 next cycle, no o_done. A new i_boot_start restarts cleanly.
